// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first, single registered carry.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } stateE;

  stateE          stateQ;
  stateE          stateNext;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic           c;
  logic [CW-1:0]  bitCnt;
  logic           lastBit;
  logic [1:0]     addBit;

  // Returns {carry, sum} of a one-bit full add.
  function automatic logic [1:0] fullAdd(input logic x, input logic y, input logic cin);
    logic s;
    logic co;
    s  = x ^ y ^ cin;
    co = (x & y) | (cin & (x ^ y));
    return {co, s};
  endfunction

  assign addBit  = fullAdd(ra[0], rb[0], c);
  assign lastBit = (bitCnt == CW'(WIDTH - 1));

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      bitCnt <= '0;
      c      <= 1'b0;
      S      <= '0;
    end else begin
      stateQ <= stateNext;
      case (stateQ)
        IDLE: begin
          if (start) begin
            ra     <= A;
            rb     <= B;
            c      <= Ci;
            bitCnt <= '0;
            S      <= '0;
          end
        end
        RUN: begin
          S      <= {addBit[0], S[WIDTH-1:1]};
          ra     <= ra >> 1;
          rb     <= rb >> 1;
          c      <= addBit[1];
          bitCnt <= bitCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the final bit, c is the carry into the MSB and addBit[1] the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (stateQ == IDLE && start) begin
      ovf <= 1'b0;
    end else if (stateQ == RUN && lastBit) begin
      ovf <= c ^ addBit[1];
    end
  end
`endif

  assign Co   = c;
  assign busy = (stateQ != IDLE);
  assign done = (stateQ == DONE);

endmodule
